muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle multiply/divide controller for the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from the EX stage and sequences a radix-2 shift-add / restoring-divide datapath over 32 iterations. It owns the HI/LO registers and raises a stall request to the hazard logic whenever a later HI/LO-touching instruction would observe an incomplete result. It sits beside the ALU in EX; results are read by MFHI/MFLO through `o_hi`/`o_lo`.

## Interface
- `ITERATIONS`, 32: iteration count of the serial datapath (operand width).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `i_start` in 1: EX holds MULT/MULTU/DIV/DIVU this cycle.
- `i_op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `i_data_1` in 32: rs operand (multiplicand/dividend), already forwarded.
- `i_data_2` in 32: rt operand (multiplier/divisor), already forwarded.
- `i_read_hilo` in 1: EX holds MFHI/MFLO.
- `i_write_hilo` in 2: bit1 MTHI, bit0 MTLO; data on `i_data_1`.
- `o_hi` out 32: HI register.
- `o_lo` out 32: LO register.
- `o_busy` out 1: sequencer not IDLE.
- `o_stall` out 1: freeze PC, IF/ID and bubble ID/EX this cycle.
- `o_done` out 1: one-cycle pulse on the cycle HI/LO receive a new result.

## Operation
- States: IDLE, RUN, FIX.
- IDLE + `i_start`:
  - Latch |operands|, for signed ops.
  - Record sign flags and op; clear the 6-bit iteration counter.
  - Go to RUN.
- DIV/DIVU with `i_data_2`==0: skip RUN and go directly to FIX with LO=32'hFFFFFFFF and HI=`i_data_1` (raw, no sign fix).
- RUN, multiply:
  - 64-bit accumulator.
  - Each cycle: if multiplier LSB set, add multiplicand to upper half; shift right 1.
- RUN, divide:
  - Restoring divide.
  - Each cycle: shift {rem,quot} left 1; trial-subtract divisor from rem (33-bit); if non-negative, commit and set quot LSB.
- Counter increments every RUN cycle; at count ITERATIONS-1, go to FIX.
- FIX, signed fixup:
  - MULT: negate the 64-bit product if signs differ.
  - DIV: quotient negative if signs differ; remainder takes the dividend's sign.
  - Write {HI,LO} (product) or HI=rem, LO=quot.
  - Pulse `o_done`; go to IDLE.
- MTHI/MTLO in IDLE: write `i_data_1` at the next edge.
- `i_start` and `i_write_hilo` together: `i_start` wins; the write is dropped.
- `o_stall` = `o_busy` & (`i_start` | `i_read_hilo` | |`i_write_hilo`). These inputs are ignored while busy; the pipeline re-presents them after the stall.
- `i_start` on the cycle FIX completes: stalled, then accepted the next cycle from IDLE.
- Arithmetic is modulo 2^32 per half. DIV of 32'h80000000 by -1 yields LO=32'h80000000, HI=0.

## Timing
- Reset values: state IDLE, counter 0, `o_hi`=0, `o_lo`=0, `o_busy`=0, `o_stall`=0, `o_done`=0.
- `i_start` sampled at edge E0:
  - RUN occupies E0..E32.
  - FIX is entered at E32.
  - HI/LO update and `o_done`=1 for the cycle after E33.
  - `o_busy` is high for the 33 cycles between E0 and E33.
- Divide-by-zero: HI/LO update at E1; busy for 1 cycle.
- Reset mid-operation: abort at that edge; HI/LO=0, no `o_done`.
- HI/LO are stable and unchanged during RUN; only FIX or MTHI/MTLO modify them.
- `o_stall` is combinational from the inputs and registered state, with no extra latency.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle 64-bit multiplier.
  - Start at E0 goes straight to FIX; HI/LO and `o_done` at E1; busy 1 cycle.
  - Divides are unchanged.
- Undefined: multiplies take the 32-iteration serial path with the same latency as divide.

## Test plan
- MULT -3 (32'hFFFFFFFD) × 5 -> after 33 cycles HI=32'hFFFFFFFF, LO=32'hFFFFFFF1; one `o_done` pulse. With the macro, the same result at E1.
- MULTU 32'hFFFFFFFF × 2 -> HI=32'h00000001, LO=32'hFFFFFFFE.
- DIV -7 / 2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU 100 / 0 -> LO=32'hFFFFFFFF, HI=32'h00000064, busy exactly 1 cycle.
- MFLO asserted 1 cycle after DIVU 9/4 -> `o_stall` high until `o_done`; LO=2, HI=1 visible when the stall drops.
- MTHI 32'h12345678 in IDLE -> HI updated next edge.
- `reset` pulsed at RUN cycle 10 -> state IDLE, HI=LO=0, no `o_done`.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
// Radix-2 shift-add multiply and restoring divide on magnitudes, with a
// signed fixup cycle (FIX) before HI/LO are written.
// Optional feature macro: MULDIV_FAST_MUL_EN -- when defined, multiplies use a
// single-cycle 64-bit multiplier and go straight to FIX; divides are unchanged.
module muldiv_sequencer #(
  parameter int ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_data_1,
  input  logic [31:0] i_data_2,
  input  logic        i_read_hilo,
  input  logic [1:0]  i_write_hilo,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;    // mul: {partial hi, multiplier/lo}; div: {rem, quot}
  logic [31:0] opnd_q, opnd_d;  // multiplicand magnitude or divisor magnitude
  logic [1:0]  op_q, op_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        dz_q, dz_d;      // divide-by-zero: acc already holds raw {HI,LO}
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        signed_op;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [64:0] div_sh;
  logic [32:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  // Next-state, datapath step and HI/LO update selection
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    signed_op = ~i_op[0];
    abs_a     = (signed_op && i_data_1[31]) ? (32'd0 - i_data_1) : i_data_1;
    abs_b     = (signed_op && i_data_2[31]) ? (32'd0 - i_data_2) : i_data_2;

    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_sh   = {acc_q, 1'b0};
    div_diff = div_sh[64:32] - {1'b0, opnd_q};

    // Magnitude results are corrected here; neg flags are zero for unsigned ops
    prod_fix = (neg_a_q ^ neg_b_q) ? (64'd0 - acc_q) : acc_q;
    quot_fix = (neg_a_q ^ neg_b_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = neg_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          op_d    = i_op;
          neg_a_d = signed_op & i_data_1[31];
          neg_b_d = signed_op & i_data_2[31];
          cnt_d   = 6'd0;
          dz_d    = 1'b0;
          busy_d  = 1'b1;
          if (i_op[1]) begin
            if (i_data_2 == 32'd0) begin
              dz_d    = 1'b1;
              acc_d   = {i_data_1, 32'hFFFF_FFFF};
              state_d = S_FIX;
            end else begin
              acc_d   = {32'd0, abs_a};
              opnd_d  = abs_b;
              state_d = S_RUN;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            acc_d   = {32'd0, abs_a} * {32'd0, abs_b};
            state_d = S_FIX;
`else
            acc_d   = {32'd0, abs_b};
            opnd_d  = abs_a;
            state_d = S_RUN;
`endif
          end
        end else begin
          // start has priority, so a simultaneous MTHI/MTLO is dropped
          if (i_write_hilo[1]) hi_d = i_data_1;
          if (i_write_hilo[0]) lo_d = i_data_1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (op_q[1]) begin
          // restoring divide: commit trial subtract when it does not borrow
          if (!div_diff[32]) acc_d = {div_diff[31:0], div_sh[31:1], 1'b1};
          else               acc_d = div_sh[63:0];
        end else begin
          // shift-add: carry out of the upper add shifts into bit 63
          acc_d = {mul_sum, acc_q[31:1]};
        end
        if (cnt_q == 6'(ITERATIONS - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (dz_q) begin
          hi_d = acc_q[63:32];
          lo_d = acc_q[31:0];
        end else if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      acc_q   <= 64'd0;
      opnd_q  <= 32'd0;
      op_q    <= 2'd0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_hi    = hi_q;
  assign o_lo    = lo_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_stall = busy_q & (i_start | i_read_hilo | (|i_write_hilo));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hand-written
// multi-cycle sequences and randomized ops against a plain-arithmetic model.
module tb_muldiv_sequencer;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_data_1, i_data_2;
  logic        i_read_hilo;
  logic [1:0]  i_write_hilo;
  logic [31:0] o_hi, o_lo;
  logic        o_busy, o_stall, o_done;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_sequencer #(.ITERATIONS(32)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_op(i_op),
    .i_data_1(i_data_1), .i_data_2(i_data_2), .i_read_hilo(i_read_hilo),
    .i_write_hilo(i_write_hilo), .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy),
    .o_stall(o_stall), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0];
        end else begin
          q = longint'(ua / ub); r = longint'(ua % ub); hi = r[31:0]; lo = q[31:0];
        end
      end
    endcase
  endtask

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    if (op[1] && b == 32'd0) return 1;
    if (!op[1] && FAST) return 1;
    return 33;
  endfunction

  // Issue one op from IDLE and check result, latency, busy length and single done pulse
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat, busy_cnt;
    logic [31:0] hi0, lo0;
    bit moved;
    hi0 = o_hi; lo0 = o_lo; moved = 0;
    i_start = 1'b1; i_op = op; i_data_1 = a; i_data_2 = b;
    tick();
    i_start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!o_done && lat < 100) begin
      if (o_busy) busy_cnt++;
      if (o_hi !== hi0 || o_lo !== lo0) moved = 1;
      tick();
      lat++;
    end
    chk({name, " hi"}, {32'd0, o_hi}, {32'd0, ehi});
    chk({name, " lo"}, {32'd0, o_lo}, {32'd0, elo});
    chk({name, " latency"}, 64'(lat), 64'(exp_lat(op, b)));
    chk({name, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat(op, b)));
    chk({name, " hilo stable while busy"}, {63'd0, moved}, 64'd0);
    tick();
    chk({name, " done single pulse"}, {63'd0, o_done}, 64'd0);
  endtask

  vec_t vt[$];

  initial begin
    logic [31:0] mhi, mlo;
    int k;
    bit bad;

    reset = 1'b1; i_start = 0; i_op = 0; i_data_1 = 0; i_data_2 = 0;
    i_read_hilo = 0; i_write_hilo = 0;
    tick(); tick();
    reset = 1'b0;
    chk("reset hi", {32'd0, o_hi}, 64'd0);
    chk("reset lo", {32'd0, o_lo}, 64'd0);
    chk("reset busy/stall/done", {61'd0, o_busy, o_stall, o_done}, 64'd0);

    // Directed table: expectations worked out by hand
    vt.push_back('{2'b00, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1});
    vt.push_back('{2'b01, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE});
    vt.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vt.push_back('{2'b11, 32'd100,       32'd0,          32'h0000_0064, 32'hFFFF_FFFF});
    vt.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000});
    vt.push_back('{2'b10, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD});
    vt.push_back('{2'b10, 32'hFFFF_FFF8, 32'd0,          32'hFFFF_FFF8, 32'hFFFF_FFFF});
    vt.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000});
    vt.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000});
    vt.push_back('{2'b11, 32'hFFFF_FFFF, 32'h0000_0010,  32'h0000_000F, 32'h0FFF_FFFF});
    foreach (vt[i]) run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo);

    // MTHI / MTLO in IDLE
    i_write_hilo = 2'b10; i_data_1 = 32'h1234_5678;
    tick();
    chk("mthi", {32'd0, o_hi}, 64'h1234_5678);
    i_write_hilo = 2'b01; i_data_1 = 32'hCAFE_F00D;
    tick();
    i_write_hilo = 2'b00;
    chk("mtlo", {o_hi, o_lo}, 64'h1234_5678_CAFE_F00D);

    // start + MTLO together: write dropped, HI/LO untouched at that edge
    i_start = 1; i_op = 2'b11; i_data_1 = 32'd9; i_data_2 = 32'd4; i_write_hilo = 2'b01;
    tick();
    i_start = 0; i_write_hilo = 0;
    chk("start beats write", {o_hi, o_lo}, 64'h1234_5678_CAFE_F00D);
    // MFLO held from the next cycle: stall must track busy until done
    i_read_hilo = 1; bad = 0; k = 0;
    while (!o_done && k < 100) begin
      if (o_stall !== 1'b1) bad = 1;
      tick(); k++;
    end
    chk("mflo stall while busy", {63'd0, bad}, 64'd0);
    chk("mflo stall drops at done", {62'd0, o_done, o_stall}, 64'd2);
    chk("divu 9/4 result", {o_hi, o_lo}, {32'd1, 32'd2});
    i_read_hilo = 0;
    tick();

    // start during FIX is stalled, then accepted from IDLE
    i_start = 1; i_op = 2'b11; i_data_1 = 32'd55; i_data_2 = 32'd0;
    tick();
    i_data_1 = 32'd77;
    chk("start in FIX stalls", {62'd0, o_busy, o_stall}, 64'd3);
    tick();
    chk("fix done, idle no stall", {61'd0, o_done, o_busy, o_stall}, 64'd4);
    tick();
    i_start = 0;
    chk("restart accepted", {63'd0, o_busy}, 64'd1);
    tick();
    chk("restart result", {o_hi, o_lo, 62'd0, o_done, o_busy}, {32'd77, 32'hFFFF_FFFF, 62'd0, 2'b10});
    tick();

    // Reset mid-operation (divide, so the serial path is exercised in every build)
    i_start = 1; i_op = 2'b10; i_data_1 = 32'd1000; i_data_2 = 32'd3;
    tick();
    i_start = 0;
    repeat (10) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("reset abort", {o_hi, o_lo, 61'd0, o_busy, o_stall, o_done}, 128'd0);
    bad = 0;
    repeat (40) begin
      tick();
      if (o_done || o_busy) bad = 1;
    end
    chk("no done after abort", {63'd0, bad}, 64'd0);

    // Randomized ops against the model
    for (int i = 0; i < 24; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'(($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1);
        2: a = 32'h8000_0000;
        3: b = $urandom_range(1, 20);
        default: ;
      endcase
      model(op, a, b, mhi, mlo);
      run_op($sformatf("rnd%0d op%0d %h %h", i, op, a, b), op, a, b, mhi, mlo);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time guard so a wedged run still reports
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
